// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: UK traffic-light sequencer for N_DIR conflicting approaches.
// Each approach in turn runs red+amber -> green -> amber, and an all-red
// clearance separates approaches. Phase lengths are programmable. The block can
// skip approaches that have no demand, and has a flashing-amber fault mode.
// Every output is a register, and the lamps are decoded from the next state.

// Lamp-safety checker, bound inside the controller. Outside FLASH, at most one
// approach may show green or amber, and no approach may show red and green together.
module tlc_checker #(
  parameter int N_DIR = 2
) (
  input logic             clk,
  input logic             rst,
  input logic [N_DIR-1:0] red,
  input logic [N_DIR-1:0] amber,
  input logic [N_DIR-1:0] green,
  input logic [2:0]       phase
);

  a_single_mover: assert property (@(posedge clk) disable iff (rst)
    (phase != 3'd4) |-> $onehot0(green | amber))
    else $error("lamp invariant: more than one approach moving");

  a_no_red_green: assert property (@(posedge clk) disable iff (rst)
    ((green & red) == {N_DIR{1'b0}}))
    else $error("lamp invariant: red and green together");

endmodule

module traffic_light_ctrl #(
  parameter int N_DIR       = 2,
  parameter int CNT_W       = 8,
  parameter int T_ALL_RED   = 1,
  parameter int T_RED_AMBER = 2,
  parameter int T_GREEN     = 8,
  parameter int T_AMBER     = 3,
  parameter int FLASH_HALF  = 2,
  parameter int DEMAND_MODE = 1,
  localparam int DIR_W      = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flash,
  input  logic [N_DIR-1:0] demand,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] amber,
  output logic [N_DIR-1:0] green,
  output logic [DIR_W-1:0] active_dir,
  output logic [2:0]       phase
);

  // The flash counter only needs to hold FLASH_HALF-1.
  localparam int FL_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  // Timer reload values. Each state lasts T_x enabled cycles, so the timer counts T_x-1 down to 0.
  localparam logic [CNT_W-1:0] LD_ALL_RED   = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LD_RED_AMBER = CNT_W'(T_RED_AMBER - 1);
  localparam logic [CNT_W-1:0] LD_GREEN     = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_AMBER     = CNT_W'(T_AMBER - 1);
  localparam logic [CNT_W-1:0] T_ZERO       = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] T_ONE        = CNT_W'(1);
  localparam logic [FL_W-1:0]  LD_FLASH     = FL_W'(FLASH_HALF - 1);
  localparam logic [FL_W-1:0]  F_ZERO       = {FL_W{1'b0}};
  localparam logic [FL_W-1:0]  F_ONE        = FL_W'(1);
  localparam logic [DIR_W-1:0] LAST_DIR     = DIR_W'(N_DIR - 1);
  localparam logic [DIR_W-1:0] DIR_ZERO     = {DIR_W{1'b0}};
  localparam logic [DIR_W-1:0] DIR_ONE      = DIR_W'(1);

  typedef enum logic [2:0] {
    PH_ALL_RED   = 3'd0,
    PH_RED_AMBER = 3'd1,
    PH_GREEN     = 3'd2,
    PH_AMBER     = 3'd3,
    PH_FLASH     = 3'd4
  } phase_t;

  // State registers.
  phase_t           r_phase;
  logic [CNT_W-1:0] r_timer;
  logic [DIR_W-1:0] r_dir;
  logic [FL_W-1:0]  r_fcnt;
  logic             r_flvl;
  logic [N_DIR-1:0] r_red;
  logic [N_DIR-1:0] r_amber;
  logic [N_DIR-1:0] r_green;

  // Next-state values.
  phase_t           w_nxt_phase;
  logic [CNT_W-1:0] w_nxt_timer;
  logic [DIR_W-1:0] w_nxt_dir;
  logic [FL_W-1:0]  w_nxt_fcnt;
  logic             w_nxt_flvl;
  logic [N_DIR-1:0] w_nxt_red;
  logic [N_DIR-1:0] w_nxt_amber;
  logic [N_DIR-1:0] w_nxt_green;

  // Result of the approach selection at ALL_RED exit.
  logic             w_sel_ok;
  logic [DIR_W-1:0] w_sel_dir;

  // Choose the next approach. In fixed rotation this is simply the next one.
  // In demand mode, the search is round-robin from active_dir+1 and wraps to
  // active_dir itself. The loop runs from the farthest offset to the nearest,
  // so the nearest requesting approach is the one that remains selected.
  always_comb begin
    logic [DIR_W-1:0] w_idx;
    logic             w_hit;
    w_sel_ok  = 1'b0;
    w_sel_dir = r_dir;
    w_idx     = DIR_ZERO;
    w_hit     = 1'b0;
    if (DEMAND_MODE == 0) begin
      w_sel_ok  = 1'b1;
      w_sel_dir = (r_dir == LAST_DIR) ? DIR_ZERO : (r_dir + DIR_ONE);
    end else begin
      for (int k = N_DIR; k >= 1; k--) begin
        w_idx     = DIR_W'((int'(r_dir) + k) % N_DIR);
        w_hit     = demand[w_idx];
        w_sel_ok  = w_sel_ok | w_hit;
        w_sel_dir = w_hit ? w_idx : w_sel_dir;
      end
    end
  end

  // Next-state sequencing. Priority runs flash first, then leaving FLASH, then en, then the timer.
  always_comb begin
    w_nxt_phase = r_phase;
    w_nxt_timer = r_timer;
    w_nxt_dir   = r_dir;
    w_nxt_fcnt  = r_fcnt;
    w_nxt_flvl  = r_flvl;
    if (flash) begin
      if (r_phase != PH_FLASH) begin
        // Entering the fault mode. The lamps start lit and run a full half-period.
        w_nxt_phase = PH_FLASH;
        w_nxt_fcnt  = LD_FLASH;
        w_nxt_flvl  = 1'b1;
      end else if (r_fcnt == F_ZERO) begin
        w_nxt_flvl = ~r_flvl;
        w_nxt_fcnt = LD_FLASH;
      end else begin
        w_nxt_fcnt = r_fcnt - F_ONE;
      end
    end else if (r_phase == PH_FLASH) begin
      // Leaving the fault mode. Always pass through a full clearance. active_dir
      // is kept, so the rotation continues from the approach served last.
      w_nxt_phase = PH_ALL_RED;
      w_nxt_timer = LD_ALL_RED;
    end else if (en) begin
      if (r_timer != T_ZERO) begin
        w_nxt_timer = r_timer - T_ONE;
      end else begin
        case (r_phase)
          PH_ALL_RED: begin
            if (w_sel_ok) begin
              w_nxt_dir   = w_sel_dir;
              w_nxt_phase = PH_RED_AMBER;
              w_nxt_timer = LD_RED_AMBER;
            end else begin
              // No demand: keep the clearance, with the timer parked at 0 so
              // the selection is tried again on every enabled cycle.
              w_nxt_timer = T_ZERO;
            end
          end
          PH_RED_AMBER: begin
            w_nxt_phase = PH_GREEN;
            w_nxt_timer = LD_GREEN;
          end
          PH_GREEN: begin
            w_nxt_phase = PH_AMBER;
            w_nxt_timer = LD_AMBER;
          end
          PH_AMBER: begin
            w_nxt_phase = PH_ALL_RED;
            w_nxt_timer = LD_ALL_RED;
          end
          default: begin
            w_nxt_phase = PH_ALL_RED;
            w_nxt_timer = LD_ALL_RED;
          end
        endcase
      end
    end else begin
      // Frozen: state and timer hold their values.
      w_nxt_timer = r_timer;
    end
  end

  // Lamp decode from the next state, so the lamps change on the same edge as the phase.
  always_comb begin
    w_nxt_red   = {N_DIR{1'b1}};
    w_nxt_amber = {N_DIR{1'b0}};
    w_nxt_green = {N_DIR{1'b0}};
    case (w_nxt_phase)
      PH_ALL_RED: begin
        w_nxt_red = {N_DIR{1'b1}};
      end
      PH_RED_AMBER: begin
        w_nxt_amber[w_nxt_dir] = 1'b1;
      end
      PH_GREEN: begin
        w_nxt_red[w_nxt_dir]   = 1'b0;
        w_nxt_green[w_nxt_dir] = 1'b1;
      end
      PH_AMBER: begin
        w_nxt_red[w_nxt_dir]   = 1'b0;
        w_nxt_amber[w_nxt_dir] = 1'b1;
      end
      PH_FLASH: begin
        w_nxt_red   = {N_DIR{1'b0}};
        w_nxt_amber = {N_DIR{w_nxt_flvl}};
      end
      default: begin
        w_nxt_red = {N_DIR{1'b1}};
      end
    endcase
  end

  // Sequencer state and registered lamp outputs, with asynchronous reset to the all-red clearance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= PH_ALL_RED;
      r_timer <= LD_ALL_RED;
      r_dir   <= LAST_DIR;
      r_fcnt  <= F_ZERO;
      r_flvl  <= 1'b0;
      r_red   <= {N_DIR{1'b1}};
      r_amber <= {N_DIR{1'b0}};
      r_green <= {N_DIR{1'b0}};
    end else begin
      r_phase <= w_nxt_phase;
      r_timer <= w_nxt_timer;
      r_dir   <= w_nxt_dir;
      r_fcnt  <= w_nxt_fcnt;
      r_flvl  <= w_nxt_flvl;
      r_red   <= w_nxt_red;
      r_amber <= w_nxt_amber;
      r_green <= w_nxt_green;
    end
  end

  assign red        = r_red;
  assign amber      = r_amber;
  assign green      = r_green;
  assign active_dir = r_dir;
  assign phase      = r_phase;

  tlc_checker #(.N_DIR(N_DIR)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .red   (r_red),
    .amber (r_amber),
    .green (r_green),
    .phase (r_phase)
  );

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl. Two instances are used:
//   u_dut0: N_DIR=2, fixed rotation.
//   u_dut1: N_DIR=4, demand skipping.
// Both use T_GREEN=4. Stimulus comes from tables of vectors. When a vector is
// driven, its expected outputs go into a scoreboard queue; they are popped and
// compared #1 after the next rising edge.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, en0, flash0;
  logic [1:0] dem0, red0, amb0, grn0;
  logic [0:0] dir0;
  logic [2:0] ph0;

  logic       rst1, en1, flash1;
  logic [3:0] dem1, red1, amb1, grn1;
  logic [1:0] dir1;
  logic [2:0] ph1;

  traffic_light_ctrl #(.N_DIR(2), .T_GREEN(4), .DEMAND_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst0), .en(en0), .flash(flash0), .demand(dem0),
    .red(red0), .amber(amb0), .green(grn0), .active_dir(dir0), .phase(ph0)
  );

  traffic_light_ctrl #(.N_DIR(4), .T_GREEN(4), .DEMAND_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst1), .en(en1), .flash(flash1), .demand(dem1),
    .red(red1), .amber(amb1), .green(grn1), .active_dir(dir1), .phase(ph1)
  );

  typedef struct {
    int         dut;
    logic       en;
    logic       flash;
    logic [3:0] demand;
    logic [2:0] ph;
    int         dir;
    logic       lvl;
  } vec_t;

  typedef struct {
    int         dut;
    logic [2:0] ph;
    logic [1:0] dir;
    logic [3:0] red;
    logic [3:0] amber;
    logic [3:0] green;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected lamp pattern for a given phase and approach, from the lamp table.
  function automatic exp_t mk_exp(int dut, logic [2:0] ph, int dir, logic lvl);
    exp_t       e;
    logic [3:0] full;
    full    = (dut == 0) ? 4'b0011 : 4'b1111;
    e.dut   = dut;
    e.ph    = ph;
    e.dir   = 2'(dir);
    e.red   = full;
    e.amber = 4'b0000;
    e.green = 4'b0000;
    case (ph)
      3'd1: e.amber[dir] = 1'b1;
      3'd2: begin e.red[dir] = 1'b0; e.green[dir] = 1'b1; end
      3'd3: begin e.red[dir] = 1'b0; e.amber[dir] = 1'b1; end
      3'd4: begin e.red = 4'b0000; e.amber = lvl ? full : 4'b0000; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic add(int dut, logic en, logic fl, logic [3:0] dm,
                     logic [2:0] ph, int dir, logic lvl, int cnt);
    vec_t v;
    v.dut = dut; v.en = en; v.flash = fl; v.demand = dm;
    v.ph = ph; v.dir = dir; v.lvl = lvl;
    for (int i = 0; i < cnt; i++) vecs.push_back(v);
  endtask

  // Pop one expectation and compare it against the instance it names.
  task automatic check_out(string name, int idx);
    exp_t       e;
    logic [2:0] a_ph;
    logic [1:0] a_dir;
    logic [3:0] a_r, a_a, a_g;
    e = sb.pop_front();
    if (e.dut == 0) begin
      a_ph = ph0; a_dir = {1'b0, dir0};
      a_r = {2'b00, red0}; a_a = {2'b00, amb0}; a_g = {2'b00, grn0};
    end else begin
      a_ph = ph1; a_dir = dir1; a_r = red1; a_a = amb1; a_g = grn1;
    end
    checks++;
    if (a_ph !== e.ph || a_dir !== e.dir || a_r !== e.red || a_a !== e.amber || a_g !== e.green) begin
      failures++;
      $display("FAIL %s[%0d] got ph=%0d dir=%0d r=%b a=%b g=%b, want ph=%0d dir=%0d r=%b a=%b g=%b",
               name, idx, a_ph, a_dir, a_r, a_a, a_g, e.ph, e.dir, e.red, e.amber, e.green);
    end
  endtask

  // Apply the queued vectors, one clock each.
  task automatic run_vecs(string name);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].dut == 0) begin
        en0 = vecs[i].en; flash0 = vecs[i].flash; dem0 = vecs[i].demand[1:0];
      end else begin
        en1 = vecs[i].en; flash1 = vecs[i].flash; dem1 = vecs[i].demand;
      end
      sb.push_back(mk_exp(vecs[i].dut, vecs[i].ph, vecs[i].dir, vecs[i].lvl));
      @(posedge clk);
      #1;
      check_out(name, i);
    end
    vecs.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst0 = 1'b1; en0 = 1'b0; flash0 = 1'b0; dem0 = 2'b00;
    rst1 = 1'b1; en1 = 1'b0; flash1 = 1'b0; dem1 = 4'b0000;
    @(negedge clk); @(negedge clk);

    // Reset state for both instances.
    sb.push_back(mk_exp(0, 3'd0, 1, 1'b0)); check_out("reset0", 0);
    sb.push_back(mk_exp(1, 3'd0, 3, 1'b0)); check_out("reset1", 0);

    // Test 1: steady fixed rotation. Period 20, approach order 0,1,0.
    @(negedge clk); rst0 = 1'b0;
    add(0, 1, 0, 0, 3'd1, 0, 0, 2); add(0, 1, 0, 0, 3'd2, 0, 0, 4);
    add(0, 1, 0, 0, 3'd3, 0, 0, 3); add(0, 1, 0, 0, 3'd0, 0, 0, 1);
    add(0, 1, 0, 0, 3'd1, 1, 0, 2); add(0, 1, 0, 0, 3'd2, 1, 0, 4);
    add(0, 1, 0, 0, 3'd3, 1, 0, 3); add(0, 1, 0, 0, 3'd0, 1, 0, 1);
    add(0, 1, 0, 0, 3'd1, 0, 0, 1);
    run_vecs("steady");

    // Test 3: en dropped for 5 cycles on the 2nd GREEN cycle. GREEN still spans 4 enabled cycles.
    add(0, 1, 0, 0, 3'd1, 0, 0, 1); add(0, 1, 0, 0, 3'd2, 0, 0, 2);
    add(0, 0, 0, 0, 3'd2, 0, 0, 5); add(0, 1, 0, 0, 3'd2, 0, 0, 2);
    add(0, 1, 0, 0, 3'd3, 0, 0, 3); add(0, 1, 0, 0, 3'd0, 0, 0, 1);
    add(0, 1, 0, 0, 3'd1, 1, 0, 2); add(0, 1, 0, 0, 3'd2, 1, 0, 2);
    run_vecs("en_freeze");

    // Test 4: flash raised during GREEN of dir1. Amber toggles every 2 cycles.
    // On exit: one all-red cycle, then RED_AMBER for dir0.
    add(0, 1, 1, 0, 3'd4, 1, 1, 2); add(0, 1, 1, 0, 3'd4, 1, 0, 2);
    add(0, 1, 1, 0, 3'd4, 1, 1, 1);
    add(0, 1, 0, 0, 3'd0, 1, 0, 1); add(0, 1, 0, 0, 3'd1, 0, 0, 2);
    add(0, 1, 0, 0, 3'd2, 0, 0, 1);
    run_vecs("flash");

    // Test 5: asynchronous reset pulse in the middle of AMBER.
    add(0, 1, 0, 0, 3'd2, 0, 0, 3); add(0, 1, 0, 0, 3'd3, 0, 0, 1);
    run_vecs("pre_rst");
    #2 rst0 = 1'b1;
    #1;
    sb.push_back(mk_exp(0, 3'd0, 1, 1'b0)); check_out("async_rst", 0);
    @(negedge clk); rst0 = 1'b0;
    add(0, 1, 0, 0, 3'd1, 0, 0, 2); add(0, 1, 0, 0, 3'd2, 0, 0, 1);
    run_vecs("restart");

    // Test 6: flash arrives on the AMBER expiry edge, with en low. flash still wins.
    add(0, 1, 0, 0, 3'd2, 0, 0, 3); add(0, 1, 0, 0, 3'd3, 0, 0, 3);
    add(0, 0, 1, 0, 3'd4, 0, 1, 1);
    add(0, 1, 0, 0, 3'd0, 0, 0, 1); add(0, 1, 0, 0, 3'd1, 1, 0, 1);
    run_vecs("collision");

    // Test 2: demand skipping on 4 approaches.
    @(negedge clk); rst1 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      add(1, 1, 0, 4'b0100, 3'd1, 2, 0, 2); add(1, 1, 0, 4'b0100, 3'd2, 2, 0, 4);
      add(1, 1, 0, 4'b0100, 3'd3, 2, 0, 3); add(1, 1, 0, 4'b0100, 3'd0, 2, 0, 1);
    end
    add(1, 1, 0, 4'b0000, 3'd0, 2, 0, 5);
    add(1, 1, 0, 4'b0010, 3'd1, 1, 0, 2);
    add(1, 1, 0, 4'b1111, 3'd2, 1, 0, 4); add(1, 1, 0, 4'b1111, 3'd3, 1, 0, 3);
    add(1, 1, 0, 4'b1111, 3'd0, 1, 0, 1); add(1, 1, 0, 4'b1111, 3'd1, 2, 0, 1);
    add(1, 1, 0, 4'b0001, 3'd1, 2, 0, 1); add(1, 1, 0, 4'b0001, 3'd2, 2, 0, 4);
    add(1, 1, 0, 4'b0001, 3'd3, 2, 0, 3); add(1, 1, 0, 4'b0001, 3'd0, 2, 0, 1);
    add(1, 1, 0, 4'b0001, 3'd1, 0, 0, 1);
    run_vecs("demand");

    // Random en/flash/demand, with the lamp invariants checked on every cycle.
    for (int c = 0; c < 400; c++) begin
      en0 = ($urandom_range(0, 3) != 0); flash0 = ($urandom_range(0, 9) == 0);
      en1 = ($urandom_range(0, 3) != 0); flash1 = ($urandom_range(0, 9) == 0);
      dem0 = 2'($urandom_range(0, 3)); dem1 = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      checks++;
      if ((ph0 != 3'd4 && !$onehot0(grn0 | amb0)) || ((grn0 & red0) != 2'b00)) begin
        failures++;
        $display("FAIL rand_inv0[%0d] got ph=%0d r=%b a=%b g=%b, want single mover and no red+green",
                 c, ph0, red0, amb0, grn0);
      end
      checks++;
      if ((ph1 != 3'd4 && !$onehot0(grn1 | amb1)) || ((grn1 & red1) != 4'b0000)) begin
        failures++;
        $display("FAIL rand_inv1[%0d] got ph=%0d r=%b a=%b g=%b, want single mover and no red+green",
                 c, ph1, red1, amb1, grn1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised UK traffic-light sequencer for N_DIR conflicting approaches at one junction. Only one approach is non-red at any time. Each served approach runs red -> red+amber -> green -> amber, and an all-red clearance interval separates approaches. Phase durations are programmable. Two further features are provided: demand-driven skipping of idle approaches, and a fault/maintenance flashing-amber mode. The block is a standalone top-level controller driving lamp outputs directly.

Parameters:
N_DIR, 2, number of approaches served in round-robin order (>=2)
CNT_W, 8, phase timer width; every T_* must lie in 1..2^CNT_W
T_ALL_RED, 1, clocks in ALL_RED clearance
T_RED_AMBER, 2, clocks in RED_AMBER
T_GREEN, 8, clocks in GREEN
T_AMBER, 3, clocks in AMBER
FLASH_HALF, 2, clocks per half-period of flashing amber
DEMAND_MODE, 1, 1 = skip approaches with no demand; 0 = fixed rotation (demand ignored)

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  1 = sequencer runs; 0 = state, timer and lamps frozen
flash  in  1  level; 1 = flashing-amber fault mode (overrides en)
demand  in  N_DIR  per-approach request, level, sampled only at ALL_RED exit
red  out  N_DIR  red lamp per approach
amber  out  N_DIR  amber lamp per approach
green  out  N_DIR  green lamp per approach
active_dir  out  DIR_W  approach currently or last served; DIR_W = max(1,clog2(N_DIR))
phase  out  3  0 ALL_RED, 1 RED_AMBER, 2 GREEN, 3 AMBER, 4 FLASH

Behaviour:
- All outputs are registered. They change on the edge at which the causing condition is sampled; there are no combinational paths from inputs to outputs.
- Reset (async, rst=1): phase=ALL_RED, red=all 1, amber=0, green=0, active_dir=N_DIR-1, timer=T_ALL_RED-1, flash counter=0. The first selected approach is therefore approach 0.
- Timer: on entry to a state the timer is loaded with T_x-1. It decrements each enabled cycle, and the state advances on the enabled cycle where timer==0. Each state thus lasts exactly T_x enabled cycles.
- Lamps by phase, for approach d=active_dir:
  - ALL_RED: all red.
  - RED_AMBER: d red+amber.
  - GREEN: d green only.
  - AMBER: d amber only.
  - In every non-FLASH phase, all other approaches show red only.
- Transitions: RED_AMBER->GREEN->AMBER->ALL_RED are unconditional at timer expiry.
- ALL_RED exit, at expiry:
  - DEMAND_MODE=0: active_dir <= (active_dir+1) mod N_DIR, go to RED_AMBER.
  - DEMAND_MODE=1: search round-robin from active_dir+1 through active_dir (inclusive, wrapping) for the first set demand bit. Select it and go to RED_AMBER. The current approach may be reselected if it is the only one with demand. If no bits are set, stay in ALL_RED with timer held at 0 and re-evaluate every enabled cycle.
- en=0 (and flash=0): nothing changes, including timer and lamps.
- FLASH:
  - flash=1 in any state: next edge enters FLASH; flash counter loads FLASH_HALF-1 and flash level loads 1.
  - Lamps in FLASH: red=0, green=0, amber=all bits equal to the flash level. The level toggles each time the flash counter expires; the counter then reloads. en is ignored.
  - flash=0 while in FLASH: next edge enters ALL_RED with timer=T_ALL_RED-1, red=all 1, active_dir unchanged. This gives a full clearance before any green.
- Reset mid-sequence returns to the reset state immediately, regardless of phase or flash.
- Simultaneous events: rst beats flash; flash beats en; a timer expiry coinciding with flash=1 goes to FLASH, not the next phase.
- Invariant, checked by assertion: at most one bit of green|amber is set outside FLASH; green and red are never both set on any approach.

Test Plan:
1. Reset then steady run, defaults with T_GREEN=4, DEMAND_MODE=0, en=1. From reset release:
   - 1 cycle ALL_RED, then dir0 RED_AMBER 2, GREEN 4, AMBER 3, ALL_RED 1, then dir1 RED_AMBER.
   - Period is 20 cycles; active_dir sequence is 0,1,0.
2. Demand skip, N_DIR=4, DEMAND_MODE=1, demand=4'b0100 constant:
   - Only dir2 is ever served; it is reselected every cycle of the rotation.
   - With demand=0 at ALL_RED expiry, the block stays all-red indefinitely. Raising demand[1] causes RED_AMBER for dir1 on the next edge.
3. en freeze: deassert en for 5 cycles on the 2nd GREEN cycle. Lamps and timer are held; after re-enable, GREEN lasts exactly 2 more enabled cycles (4 total).
4. Flash mode: assert flash during GREEN of dir1.
   - Next edge: red=0, green=0, amber=all 1. Amber then toggles every 2 cycles.
   - Deassert flash: next edge shows all red, followed by RED_AMBER after T_ALL_RED. That RED_AMBER is for dir0 when DEMAND_MODE=0, because rotation continues from active_dir=1.
5. Async reset mid-AMBER: pulse rst between clock edges. Outputs go to red=all 1, amber=0, green=0, phase=0, active_dir=N_DIR-1 without waiting for a clock edge; the sequence restarts as in test 1.
6. Collision: flash rises on the same edge as AMBER timer expiry. The next phase is FLASH, not ALL_RED. Run the lamp invariant assertion throughout all tests with random en/flash/demand.
